// File: rtl/alu_nbit_seq_if.sv
// alu_nbit_seq_if
//   Operand/result bundle for alu_nbit_seq. It carries two valid/ready channels:
//   an operand channel (in_*, op, a, b) and a result channel (out_*, result, flags).
//   master : operand source / result consumer side
//   slave  : the ALU side
//   Signals:
//     in_valid, in_ready     operand handshake
//     op[2:0], a, b          operation code and operands
//     out_valid, out_ready   result handshake
//     result                 registered result
//     flag_z/n/c/v           zero, negative, carry/borrow/shift-out, signed overflow
interface alu_nbit_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq
//   WIDTH-bit registered ALU with one operation in flight at a time.
//   Logic and arithmetic ops complete in one cycle. Shifts run serially,
//   one bit per cycle, so an N-bit shift takes 1+N cycles from accept to out_valid.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_nbit_seq_if.slave (operand channel in, result channel out)
//   op: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 ADD, 101 SUB, 110 SHL, 111 SHR
module alu_nbit_seq #(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           rst_n,
  alu_nbit_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  localparam int MSB = WIDTH - 1;

  state_e               state;
  state_e               state_next;
  logic                 in_ready_q;
  logic [WIDTH-1:0]     result_q;
  logic                 z_q;
  logic                 n_q;
  logic                 c_q;
  logic                 v_q;
  logic [SHAMT_W-1:0]   cnt_q;      // shifts still to do
  logic                 shr_q;      // direction of the shift in progress

  op_e                  op_in;
  logic [SHAMT_W-1:0]   shamt;
  logic                 accept;
  logic                 is_shift;
  logic                 start_shift;

  assign op_in       = op_e'(bus.op);
  assign shamt       = bus.b[SHAMT_W-1:0];
  // in_ready_q is only ever high in IDLE, so it alone qualifies an accept.
  assign accept      = bus.in_valid & in_ready_q;
  assign is_shift    = (op_in == OP_SHL) || (op_in == OP_SHR);
  assign start_shift = is_shift && (shamt != '0);

  // Single-cycle ALU
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  // Top bit of the widened difference is the unsigned borrow (a < b).
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_in)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_NOT: alu_res = ~bus.a;
      OP_ADD: begin
        {alu_c, alu_res} = sum;
        alu_v = (bus.a[MSB] == bus.b[MSB]) && (alu_res[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        {alu_c, alu_res} = diff;
        alu_v = (bus.a[MSB] != bus.b[MSB]) && (alu_res[MSB] != bus.a[MSB]);
      end
      // Zero-count shifts pass a through; non-zero counts go through SHIFT instead.
      OP_SHL, OP_SHR: alu_res = bus.a;
      default:        alu_res = '0;
    endcase
  end

  // One serial shift step on the working register
  logic [WIDTH-1:0] step_res;
  logic             step_c;

  always_comb begin
    if (shr_q) begin
      step_res = {1'b0, result_q[MSB:1]};
      step_c   = result_q[0];
    end else begin
      step_res = {result_q[MSB-1:0], 1'b0};
      step_c   = result_q[MSB];
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt_q == SHAMT_W'(1)) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath. result_q doubles as the shift register; z/n track each step,
  // so after the last step they describe the final result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b0;
      result_q   <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      cnt_q      <= '0;
      shr_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      // Registered so it stays low through reset and the handoff edge.
      in_ready_q <= (state_next == IDLE);
      if (accept) begin
        shr_q <= (op_in == OP_SHR);
        if (start_shift) begin
          result_q <= bus.a;
          cnt_q    <= shamt;
          z_q      <= 1'b0;
          n_q      <= 1'b0;
          c_q      <= 1'b0;
          v_q      <= 1'b0;
        end else begin
          result_q <= alu_res;
          z_q      <= (alu_res == '0);
          n_q      <= alu_res[MSB];
          c_q      <= alu_c;
          v_q      <= alu_v;
        end
      end else if (state == SHIFT) begin
        result_q <= step_res;
        cnt_q    <= cnt_q - SHAMT_W'(1);
        z_q      <= (step_res == '0);
        n_q      <= step_res[MSB];
        c_q      <= step_c;
        v_q      <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb_alu_nbit_seq
//   Table-driven bench for alu_nbit_seq (WIDTH=8). Expected results are pushed
//   to a scoreboard queue on accept and popped when out_valid is seen, along
//   with the expected accept-to-out_valid latency. Hand-written sequences cover
//   result backpressure and reset in the middle of a shift.
module tb_alu_nbit_seq;
  localparam int W = 8;

  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, XOR_ = 3'b010, NOT_ = 3'b011,
                         ADD_ = 3'b100, SUB_ = 3'b101, SHL_ = 3'b110, SHR_ = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_nbit_seq_if #(.WIDTH(W)) bus ();

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string          name;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   res;
    logic           z, n, c, v;
    int             lat;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] res,
                              input logic z, input logic n, input logic c, input logic v,
                              input int lat);
    vec_t t;
    t.name = name; t.op = op; t.a = a; t.b = b; t.res = res;
    t.z = z; t.n = n; t.c = c; t.v = v; t.lat = lat;
    return t;
  endfunction

  // Wait for in_ready, present one operation for exactly one accept edge,
  // then scramble the operand bus (operands need not be held).
  task automatic start_op(input vec_t t);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check({t.name, " in_ready before accept"}, 32'(bus.in_ready), 32'(1));
    bus.in_valid = 1'b1;
    bus.op       = t.op;
    bus.a        = t.a;
    bus.b        = t.b;
    tick();
    sb.push_back(t);
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
  endtask

  // Called right after the accept edge: measure latency, compare against
  // the scoreboard head, then hand the result off.
  task automatic finish_op();
    vec_t e;
    int   lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: output seen with no expected entry");
    end else begin
      e = sb.pop_front();
      check({e.name, " out_valid"}, 32'(bus.out_valid), 32'(1));
      check({e.name, " latency"}, 32'(lat), 32'(e.lat));
      check({e.name, " result"}, 32'(bus.result), 32'(e.res));
      check({e.name, " flags zncv"}, 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}),
            32'({e.z, e.n, e.c, e.v}));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("handoff out_valid", 32'(bus.out_valid), 32'(0));
    check("handoff in_ready", 32'(bus.in_ready), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;

    //            name          op    a      b      res    z  n  c  v  lat
    vecs.push_back(mk("add_ff_01",  ADD_, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0, 1));
    vecs.push_back(mk("sub_80_01",  SUB_, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1, 1));
    vecs.push_back(mk("sub_01_02",  SUB_, 8'h01, 8'h02, 8'hFF, 0, 1, 1, 0, 1));
    vecs.push_back(mk("shl_81_3",   SHL_, 8'h81, 8'h03, 8'h08, 0, 0, 0, 0, 4));
    vecs.push_back(mk("shr_81_1",   SHR_, 8'h81, 8'h01, 8'h40, 0, 0, 1, 0, 2));
    vecs.push_back(mk("shl_cnt0",   SHL_, 8'h5A, 8'h08, 8'h5A, 0, 0, 0, 0, 1));
    vecs.push_back(mk("not_5a",     NOT_, 8'h5A, 8'hFF, 8'hA5, 0, 1, 0, 0, 1));
    vecs.push_back(mk("and_f0_3c",  AND_, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 1));
    vecs.push_back(mk("or_f0_3c",   OR_,  8'hF0, 8'h3C, 8'hFC, 0, 1, 0, 0, 1));
    vecs.push_back(mk("xor_f0_3c",  XOR_, 8'hF0, 8'h3C, 8'hCC, 0, 1, 0, 0, 1));
    vecs.push_back(mk("add_7f_01",  ADD_, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1, 1));
    vecs.push_back(mk("add_80_80",  ADD_, 8'h80, 8'h80, 8'h00, 1, 0, 1, 1, 1));
    vecs.push_back(mk("sub_05_05",  SUB_, 8'h05, 8'h05, 8'h00, 1, 0, 0, 0, 1));
    vecs.push_back(mk("shr_80_7",   SHR_, 8'h80, 8'h07, 8'h01, 0, 0, 0, 0, 8));
    vecs.push_back(mk("shl_ff_7",   SHL_, 8'hFF, 8'hF7, 8'h80, 0, 1, 1, 0, 8));
    vecs.push_back(mk("shr_01_1",   SHR_, 8'h01, 8'h01, 8'h00, 1, 0, 1, 0, 2));

    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("reset in_ready", 32'(bus.in_ready), 32'(0));
    check("reset out_valid", 32'(bus.out_valid), 32'(0));
    check("reset result", 32'(bus.result), 32'(0));
    check("reset flags", 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready before first edge", 32'(bus.in_ready), 32'(0));
    tick();
    check("in_ready after first edge", 32'(bus.in_ready), 32'(1));

    // Table-driven vectors
    foreach (vecs[i]) begin
      start_op(vecs[i]);
      finish_op();
    end

    // Backpressure: result held while in_valid toggles with fresh operands
    start_op(mk("bp_add", ADD_, 8'h12, 8'h34, 8'h46, 0, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0] ? 1'b0 : 1'b1;
      bus.op       = SUB_;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      tick();
      check("bp out_valid held", 32'(bus.out_valid), 32'(1));
      check("bp in_ready low", 32'(bus.in_ready), 32'(0));
      check("bp result stable", 32'(bus.result), 32'(8'h46));
      check("bp flags stable", 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'(0));
    end
    bus.in_valid = 1'b0;
    finish_op();
    check("bp nothing queued", 32'(sb.size()), 32'(0));
    start_op(mk("bp_next_sub", SUB_, 8'h10, 8'h01, 8'h0F, 0, 0, 0, 0, 1));
    finish_op();

    // Reset during the third shift cycle of SHR by 7
    t = mk("rst_shr", SHR_, 8'hF0, 8'h07, 8'h01, 0, 0, 1, 0, 8);
    start_op(t);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid-shift reset out_valid", 32'(bus.out_valid), 32'(0));
    check("mid-shift reset result", 32'(bus.result), 32'(0));
    check("mid-shift reset in_ready", 32'(bus.in_ready), 32'(0));
    check("mid-shift reset flags", 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready before edge", 32'(bus.in_ready), 32'(0));
    check("post-reset out_valid", 32'(bus.out_valid), 32'(0));
    tick();
    check("post-reset in_ready after edge", 32'(bus.in_ready), 32'(1));
    start_op(mk("post_rst_add", ADD_, 8'h20, 8'h22, 8'h42, 0, 0, 0, 0, 1));
    finish_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
